// File: rtl/jam_param_engine.sv
// rtl/jam_param_engine.sv - exhaustive job-assignment solver over an external NxN cost table
//
// Purpose: walks every worker-to-job permutation in lexicographic order, reading
// cost[W][J] for each worker, and reports the minimum total cost and how many
// permutations reach it.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous active-high reset
//   Start      in   1      run request, sampled only in IDLE
//   W          out  IW     worker index of the current cost read (registered)
//   J          out  IW     job index of the current cost read (registered)
//   Cost       in   CW     cost[W][J], sampled on the edge after W/J change
//   Busy       out  1      run in progress
//   Valid      out  1      one-cycle pulse when MinCost/MatchCount are updated
//   MinCost    out  SW     minimum total cost of the last completed run
//   MatchCount out  CNT_W  number of optimal permutations, saturating

module jam_param_engine #(
  parameter int N     = 8,
  parameter int CW    = 7,
  parameter int IW    = 3,
  parameter int SW    = 10,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  output logic [IW-1:0]    W,
  output logic [IW-1:0]    J,
  input  logic [CW-1:0]    Cost,
  output logic             Busy,
  output logic             Valid,
  output logic [SW-1:0]    MinCost,
  output logic [CNT_W-1:0] MatchCount
);

  // Fetch counter must reach N, which may equal 2**IW.
  localparam int CTW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_CMP, S_PIVOT, S_SWAP, S_REV, S_DONE
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    perm_q [N];
  logic [IW-1:0]    W_q, J_q;
  logic             Busy_q, Valid_q;
  logic [SW-1:0]    MinCost_q, min_q, sum_q, sum_d;
  logic [CNT_W-1:0] MatchCount_q, cnt_q;
  logic [CTW-1:0]   idx_q;
  logic [IW-1:0]    k_q, lo_q, hi_q;

  logic             has_pivot;
  logic [IW-1:0]    piv_k, swap_l;

  assign W          = W_q;
  assign J          = J_q;
  assign Busy       = Busy_q;
  assign Valid      = Valid_q;
  assign MinCost    = MinCost_q;
  assign MatchCount = MatchCount_q;

  // Cost belongs to the address registered on the previous edge.
  assign sum_d = sum_q + SW'(Cost);

  // Next-permutation helpers: the largest rising position k (none means the
  // permutation is descending, i.e. the last one) and the largest l > k with
  // perm[l] > perm[k].
  always_comb begin
    has_pivot = 1'b0;
    piv_k     = '0;
    swap_l    = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        has_pivot = 1'b1;
        piv_k     = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (IW'(i) > k_q && perm_q[i] > perm_q[k_q]) begin
        swap_l = IW'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
      W_q          <= '0;
      J_q          <= '0;
      Busy_q       <= 1'b0;
      Valid_q      <= 1'b0;
      MinCost_q    <= '0;
      MatchCount_q <= '0;
      min_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      k_q          <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
    end else begin
      Valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            Busy_q  <= 1'b1;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
          min_q   <= '1;
          cnt_q   <= '0;
          idx_q   <= '0;
          Busy_q  <= 1'b1;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          // N address cycles plus one trailing cycle to collect the last Cost.
          if (idx_q != CTW'(N)) begin
            W_q <= idx_q[IW-1:0];
            J_q <= perm_q[idx_q[IW-1:0]];
          end
          sum_q <= (idx_q == '0) ? '0 : sum_d;
          idx_q <= idx_q + CTW'(1);
          if (idx_q == CTW'(N)) state_q <= S_CMP;
        end
        S_CMP: begin
          if (sum_q < min_q) begin
            min_q <= sum_q;
            cnt_q <= CNT_W'(1);
          end else if (sum_q == min_q && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          state_q <= has_pivot ? S_PIVOT : S_DONE;
        end
        S_PIVOT: begin
          k_q     <= piv_k;
          state_q <= S_SWAP;
        end
        S_SWAP: begin
          perm_q[k_q]    <= perm_q[swap_l];
          perm_q[swap_l] <= perm_q[k_q];
          lo_q           <= k_q + IW'(1);
          hi_q           <= IW'(N - 1);
          state_q        <= S_REV;
        end
        S_REV: begin
          if (lo_q < hi_q) begin
            perm_q[lo_q] <= perm_q[hi_q];
            perm_q[hi_q] <= perm_q[lo_q];
            lo_q         <= lo_q + IW'(1);
            hi_q         <= hi_q - IW'(1);
          end else begin
            idx_q   <= '0;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          MinCost_q    <= min_q;
          MatchCount_q <= cnt_q;
          Valid_q      <= 1'b1;
          Busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
